// File: rtl/uart_rx_pkt_parser.sv
// Frames UART bytes as SOF, LEN, payload, CHK and checks the XOR checksum, then replays accepted payloads on a valid/ready stream.
// Define UART_RX_PKT_TIMEOUT_EN to abort partial frames after TIMEOUT_CYCLES idle cycles.
module uart_rx_pkt_parser #(
    parameter logic [7:0] SOF_BYTE       = 8'hA5,
    parameter int          MAX_LEN        = 16,
    parameter int          TIMEOUT_CYCLES = 10000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last,
    output logic [7:0] pkt_len,
    output logic       err_chk,
    output logic       err_len,
    output logic       err_drop,
    output logic       err_timeout
);
    localparam int         AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    if (MAX_LEN < 1 || MAX_LEN > 255 || TIMEOUT_CYCLES < 2) begin : g_bad_param
        $error("uart_rx_pkt_parser: MAX_LEN must be 1..255 and TIMEOUT_CYCLES >= 2");
    end

    typedef enum logic [2:0] {HUNT, LEN, PAYLOAD, CHK, DRAIN} state_t;

    state_t          state_q, state_d;
    logic [7:0]      pkt_len_q, pkt_len_d;
    logic [7:0]      chk_q, chk_d;
    logic [AW-1:0]   wptr_q, wptr_d;
    logic [AW-1:0]   rptr_q, rptr_d;
    logic [7:0]      out_data_q, out_data_d;
    logic            out_valid_q, out_valid_d;
    logic            out_last_q, out_last_d;
    logic            err_chk_q, err_chk_d;
    logic            err_len_q, err_len_d;
    logic            err_drop_q, err_drop_d;
    logic            buf_we;
    logic [7:0]      pbuf [MAX_LEN];

`ifdef UART_RX_PKT_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    logic [TW-1:0] tmo_q, tmo_d;
    logic          err_timeout_q, err_timeout_d;
`endif

    always_comb begin
        state_d     = state_q;
        pkt_len_d   = pkt_len_q;
        chk_d       = chk_q;
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        err_chk_d   = 1'b0;
        err_len_d   = 1'b0;
        err_drop_d  = 1'b0;
        buf_we      = 1'b0;
        case (state_q)
            HUNT: begin
                if (rx_valid && rx_data == SOF_BYTE) state_d = LEN;
            end
            LEN: begin
                if (rx_valid) begin
                    if (rx_data == 8'd0 || rx_data > MAX_LEN_B) begin
                        err_len_d = 1'b1;
                        state_d   = HUNT;
                    end else begin
                        pkt_len_d = rx_data;
                        chk_d     = rx_data;
                        wptr_d    = '0;
                        state_d   = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                if (rx_valid) begin
                    buf_we = 1'b1;
                    chk_d  = chk_q ^ rx_data;
                    wptr_d = wptr_q + AW'(1);
                    if (8'(wptr_q) == pkt_len_q - 8'd1) state_d = CHK;
                end
            end
            CHK: begin
                if (rx_valid) begin
                    if (rx_data == chk_q) begin
                        // Preload the first byte so out_valid rises right after the CHK edge
                        state_d     = DRAIN;
                        out_valid_d = 1'b1;
                        out_data_d  = pbuf[AW'(0)];
                        out_last_d  = (pkt_len_q == 8'd1);
                        rptr_d      = AW'(1);
                    end else begin
                        err_chk_d = 1'b1;
                        state_d   = HUNT;
                    end
                end
            end
            DRAIN: begin
                err_drop_d = rx_valid;
                if (out_valid_q && out_ready) begin
                    if (out_last_q) begin
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        state_d     = HUNT;
                    end else begin
                        out_data_d = pbuf[rptr_q];
                        out_last_d = (8'(rptr_q) == pkt_len_q - 8'd1);
                        rptr_d     = rptr_q + AW'(1);
                    end
                end
            end
            default: state_d = HUNT;
        endcase
`ifdef UART_RX_PKT_TIMEOUT_EN
        tmo_d         = '0;
        err_timeout_d = 1'b0;
        if ((state_q == LEN || state_q == PAYLOAD || state_q == CHK) && !rx_valid) begin
            if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                err_timeout_d = 1'b1;
                state_d       = HUNT;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (buf_we) pbuf[wptr_q] <= rx_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= HUNT;
            pkt_len_q   <= '0;
            chk_q       <= '0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            err_chk_q   <= 1'b0;
            err_len_q   <= 1'b0;
            err_drop_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pkt_len_q   <= pkt_len_d;
            chk_q       <= chk_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            err_chk_q   <= err_chk_d;
            err_len_q   <= err_len_d;
            err_drop_q  <= err_drop_d;
        end
    end

`ifdef UART_RX_PKT_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q         <= '0;
            err_timeout_q <= 1'b0;
        end else begin
            tmo_q         <= tmo_d;
            err_timeout_q <= err_timeout_d;
        end
    end
    assign err_timeout = err_timeout_q;
`else
    assign err_timeout = 1'b0;
`endif

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign pkt_len   = pkt_len_q;
    assign err_chk   = err_chk_q;
    assign err_len   = err_len_q;
    assign err_drop  = err_drop_q;

endmodule

// File: tb/tb_uart_rx_pkt_parser.sv
// Directed bench for uart_rx_pkt_parser; the timeout scenario follows UART_RX_PKT_TIMEOUT_EN.
module tb_uart_rx_pkt_parser;
    localparam int TMO = 50;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_last;
    logic [7:0] pkt_len;
    logic       err_chk, err_len, err_drop, err_timeout;

    uart_rx_pkt_parser #(.SOF_BYTE(8'hA5), .MAX_LEN(16), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .pkt_len(pkt_len), .err_chk(err_chk),
        .err_len(err_len), .err_drop(err_drop), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s: %0h", tag, got);
        end
    endtask

    // Monitor samples on the falling edge; inputs change 1 time unit after the rising edge
    logic [8:0] xq[$];
    int         cnt_chk = 0, cnt_len = 0, cnt_drop = 0, cnt_tmo = 0;
    logic       prev_valid = 1'b0, prev_ready = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic [3:0] prev_err = 4'h0;

    always @(negedge clk) begin : mon
        logic [3:0] errs;
        errs = {err_chk, err_len, err_drop, err_timeout};
        if (rst_n) begin
            if (out_valid && out_ready) xq.push_back({out_last, out_data});
            if (prev_valid && !prev_ready && out_valid) check_eq("stall_hold", {24'h0, out_data}, {24'h0, prev_data});
            if (errs != 4'h0) begin
                check_eq("err_onehot", $countones(errs), 1);
                check_eq("err_width", {28'h0, prev_err & errs}, 32'h0);
            end
            if (err_chk)     cnt_chk  <= cnt_chk + 1;
            if (err_len)     cnt_len  <= cnt_len + 1;
            if (err_drop)    cnt_drop <= cnt_drop + 1;
            if (err_timeout) cnt_tmo  <= cnt_tmo + 1;
        end
        prev_valid <= out_valid;
        prev_ready <= out_ready;
        prev_data  <= out_data;
        prev_err   <= errs;
    end

    logic [7:0] exp_q[$];

    // Caller must be at posedge+1; leaves the bench at posedge+1 after the sampling edge
    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_frame(input logic [7:0] len, input logic [7:0] chk);
        send(8'hA5);
        send(len);
        foreach (exp_q[i]) send(exp_q[i]);
        send(chk);
    endtask

    task automatic expect_pkt(input string tag);
        int k;
        k = 0;
        while (xq.size() < exp_q.size() && k < 300) begin
            @(posedge clk); #1;
            k++;
        end
        idle(2);
        check_eq({tag, "_count"}, xq.size(), exp_q.size());
        foreach (exp_q[i]) begin
            if (i < xq.size()) begin
                check_eq($sformatf("%s_data%0d", tag, i), {24'h0, xq[i][7:0]}, {24'h0, exp_q[i]});
                check_eq($sformatf("%s_last%0d", tag, i), {31'h0, xq[i][8]}, {31'h0, (i == exp_q.size() - 1)});
            end
        end
        check_eq({tag, "_valid_low"}, {31'h0, out_valid}, 32'h0);
        xq.delete();
    endtask

    initial begin : stim
        logic [3:0] pat;
        int k;
        int tot;
        pat = 4'b1001;

        // Reset state
        idle(3);
        check_eq("rst_out_valid", {31'h0, out_valid}, 0);
        check_eq("rst_out_last", {31'h0, out_last}, 0);
        check_eq("rst_out_data", {24'h0, out_data}, 0);
        check_eq("rst_pkt_len", {24'h0, pkt_len}, 0);
        check_eq("rst_errs", {28'h0, err_chk, err_len, err_drop, err_timeout}, 0);
        rst_n = 1'b1;
        idle(2);

        // Good frame, ready held high: three consecutive transfers
        out_ready = 1'b1;
        exp_q = {8'h11, 8'h22, 8'h33};
        send_frame(8'h03, 8'h03);
        check_eq("lat_valid", {31'h0, out_valid}, 1);
        check_eq("lat_data", {24'h0, out_data}, 32'h11);
        idle(3);
        check_eq("b2b_count", xq.size(), 3);
        check_eq("b2b_valid_low", {31'h0, out_valid}, 0);
        expect_pkt("good");
        check_eq("good_pkt_len", {24'h0, pkt_len}, 3);

        // Checksum mismatch, then a good frame
        exp_q = {8'h11, 8'h22, 8'h33};
        send_frame(8'h03, 8'h04);
        check_eq("chk_pulse", {31'h0, err_chk}, 1);
        check_eq("chk_no_valid", {31'h0, out_valid}, 0);
        idle(4);
        check_eq("chk_no_xfer", xq.size(), 0);
        exp_q = {8'hAA, 8'hBB};
        send_frame(8'h02, 8'h13);
        expect_pkt("after_chk");

        // Garbage ignored, bad LEN values rejected
        send(8'h00); send(8'hFF);
        send(8'hA5); send(8'h00);
        check_eq("len0_pulse", {31'h0, err_len}, 1);
        send(8'hA5); send(8'h11);
        check_eq("len17_pulse", {31'h0, err_len}, 1);
        idle(2);

        // LEN == MAX_LEN fills the buffer exactly; XOR of 10,01..10 is 00
        exp_q = {};
        for (int i = 1; i <= 16; i++) exp_q.push_back(8'(i));
        send_frame(8'h10, 8'h00);
        expect_pkt("maxlen");
        check_eq("maxlen_pkt_len", {24'h0, pkt_len}, 16);

        // Stalled drain with ready pattern 1,0,0,1
        out_ready = 1'b0;
        exp_q = {8'h11, 8'h22, 8'h33};
        send_frame(8'h03, 8'h03);
        k = 0;
        while (xq.size() < 3 && k < 40) begin
            out_ready = pat[k % 4];
            @(posedge clk); #1;
            k++;
        end
        out_ready = 1'b1;
        expect_pkt("stall");
        check_eq("stall_pkt_len_hold", {24'h0, pkt_len}, 3);

        // Byte during stalled drain is dropped
        out_ready = 1'b0;
        exp_q = {8'h77};
        send_frame(8'h01, 8'h76);
        idle(2);
        send(8'h5A);
        check_eq("drop_pulse", {31'h0, err_drop}, 1);
        check_eq("drop_data_kept", {24'h0, out_data}, 32'h77);
        out_ready = 1'b1;
        expect_pkt("drop");

        // Reset mid-PAYLOAD loses the frame silently
        tot = cnt_chk + cnt_len + cnt_drop + cnt_tmo;
        send(8'hA5); send(8'h03); send(8'h11);
        rst_n = 1'b0;
        idle(2);
        check_eq("midrst_valid", {31'h0, out_valid}, 0);
        rst_n = 1'b1;
        idle(1);
        exp_q = {8'hAA, 8'hBB};
        send_frame(8'h02, 8'h13);
        expect_pkt("after_rst");
        check_eq("midrst_no_err", cnt_chk + cnt_len + cnt_drop + cnt_tmo, tot);

        // Partial frame followed by a long idle gap
        send(8'hA5); send(8'h02); send(8'h11);
        idle(60);
`ifdef UART_RX_PKT_TIMEOUT_EN
        check_eq("tmo_count", cnt_tmo, 1);
        exp_q = {8'hAA, 8'hBB};
        send_frame(8'h02, 8'h13);
        expect_pkt("after_tmo");
`else
        check_eq("tmo_count", cnt_tmo, 0);
        send(8'h22); send(8'h31);
        exp_q = {8'h11, 8'h22};
        expect_pkt("no_tmo");
`endif

        check_eq("total_err_chk", cnt_chk, 1);
        check_eq("total_err_len", cnt_len, 2);
        check_eq("total_err_drop", cnt_drop, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_rx_pkt_parser.md
Name: uart_rx_pkt_parser

Overview:
Downstream consumer of the UART receiver's byte stream (8-bit data plus single-cycle valid pulse, no backpressure). Frames bytes into packets of the form SOF, LEN, LEN payload bytes, CHK. Checks the frame and buffers the payload. Once a frame is accepted, replays the payload on a valid/ready stream to the command/register layer.

Parameters:
SOF_BYTE, 8'hA5, start-of-frame marker.
MAX_LEN, 16, maximum payload bytes (1..255); sizes the internal buffer.
TIMEOUT_CYCLES, 10000, inter-byte timeout in clk cycles (used only with the optional feature).

Ports:
clk  in  1  system clock
rst_n  in  1  reset
rx_data  in  8  byte from UART receiver
rx_valid  in  1  one-cycle pulse, rx_data valid
out_data  out  8  payload byte
out_valid  out  1  out_data valid
out_ready  in  1  consumer accepts byte
out_last  out  1  high with final payload byte
pkt_len  out  8  LEN of the packet being drained
err_chk  out  1  one-cycle pulse: checksum mismatch
err_len  out  1  one-cycle pulse: LEN==0 or LEN>MAX_LEN
err_drop  out  1  one-cycle pulse: byte arrived while draining, discarded
err_timeout  out  1  one-cycle pulse: inter-byte timeout (optional feature)

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk.
  - State goes to HUNT.
  - All outputs 0; buffer contents don't-care.
  - Write pointer, read pointer and running checksum cleared.
- Only cycles with rx_valid=1 consume a byte. rx_data is ignored otherwise.
- Running checksum: 8-bit XOR of LEN and all payload bytes.
- HUNT:
  - Byte==SOF_BYTE -> LEN.
  - Any other byte is discarded silently.
- LEN:
  - Byte==0 or byte>MAX_LEN -> pulse err_len, -> HUNT.
  - Otherwise latch pkt_len, checksum=byte, write pointer=0, -> PAYLOAD.
- PAYLOAD:
  - Each byte is written to buf[wptr], wptr++, and XORed into the checksum.
  - When wptr reaches pkt_len -> CHK.
- CHK:
  - Byte==checksum -> DRAIN, rptr=0.
  - Mismatch -> pulse err_chk, -> HUNT.
- DRAIN:
  - out_valid=1, out_data=buf[rptr], out_last=(rptr==pkt_len-1).
  - Transfer occurs on out_valid&&out_ready; rptr++ on each transfer.
  - Transfer with out_last=1 -> HUNT; out_valid drops the next cycle.
  - out_data is stable while out_valid && !out_ready.
- Latency: out_valid rises on the cycle after the clock edge that samples the CHK byte.
- rx_valid during DRAIN: byte discarded, err_drop pulsed. A SOF byte arriving during DRAIN is not honoured.
- pkt_len holds its value after drain until the next LEN is accepted.
- Error pulses are registered, asserted exactly one cycle, and never asserted simultaneously.
- LEN==MAX_LEN is legal and fills the buffer exactly. There is no wrap-around within a packet.
- Reset mid-frame or mid-drain: the packet is lost, no error pulse, returns to HUNT.

Optional Feature:
- Macro: UART_RX_PKT_TIMEOUT_EN.
- Defined:
  - A counter runs in LEN, PAYLOAD and CHK. It is cleared on every rx_valid and on entry to those states.
  - Reaching TIMEOUT_CYCLES-1 without a byte: pulse err_timeout, discard the partial frame, -> HUNT.
  - HUNT and DRAIN never time out.
- Not defined: no counter logic; err_timeout tied to 0.

Test Plan:
- Good frame A5 03 11 22 33 03 with out_ready=1 -> out_data 11, 22, 33 on consecutive cycles; out_last with 33; pkt_len=3; no error pulses.
- Same frame with CHK=04 -> err_chk single pulse one cycle after the CHK byte; out_valid never asserts; the next good frame is parsed normally.
- A5 00, and A5 11 (17>MAX_LEN=16) -> err_len pulse each time; leading garbage bytes 00 FF before A5 are ignored without error.
- Good frame, out_ready toggling 1,0,0,1,... -> out_data held stable while stalled; all 3 bytes delivered in order; returns to HUNT after the last transfer.
- Send byte 5A while DRAIN is stalled (out_ready=0) -> err_drop pulse; the drained payload is unchanged. Also: assert rst_n low mid-PAYLOAD, then send a good frame -> parsed correctly, no error pulses.
- With UART_RX_PKT_TIMEOUT_EN and TIMEOUT_CYCLES=50: send A5 02 11, then idle 60 cycles -> err_timeout pulse; a subsequent full frame is accepted. Without the macro, err_timeout stays 0.
